// File: rtl/first_nios2_system_sysid_pkg.sv
// Shared definitions for the system-ID check sequencer: FSM encoding, slave word
// addresses and the default expected contents of the sysid slave.
package first_nios2_system_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ID_A  = 3'd1,
        ST_ID_S  = 3'd2,
        ST_TS_A  = 3'd3,
        ST_TS_S  = 3'd4,
        ST_CPU_A = 3'd5,
        ST_CPU_S = 3'd6
    } sysid_state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1521151335;

endpackage

// File: rtl/first_nios2_system_sysid_recheck_timer.sv
// Free-running period counter 0..PERIOD-1 that emits a one-cycle tick on its
// terminal count; PERIOD = 0 keeps the tick permanently low.
module first_nios2_system_sysid_recheck_timer #(
    parameter int PERIOD = 0
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam bit           ENABLED = (PERIOD > 0);
    localparam int           W       = ENABLED ? $clog2(PERIOD + 1) : 1;
    localparam logic [W-1:0] LAST    = ENABLED ? W'(PERIOD - 1) : '0;

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = ENABLED && (count == LAST);

endmodule

// File: rtl/first_nios2_system_sysid_ctrl.sv
// Sequencer/arbiter in front of the sysid slave: runs ID/timestamp checks and
// shares the slave with a CPU-side Avalon-MM read port, one 2-cycle slot at a time.
module first_nios2_system_sysid_ctrl
    import first_nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter logic        AUTO_CHECK     = 1'b1,
    parameter int          RECHECK_PERIOD = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        cpu_read,
    input  logic        cpu_address,
    output logic [31:0] cpu_readdata,
    output logic        cpu_waitrequest,
    output logic        sid_address,
    input  logic [31:0] sid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] captured_ts
);

    sysid_state_t state;
    sysid_state_t state_nxt;
    logic         pending;
    logic         after_check;
    logic         timer_tick;
    logic         launch_check;
    logic         launch_cpu;

    first_nios2_system_sysid_recheck_timer #(
        .PERIOD(RECHECK_PERIOD)
    ) u_recheck_timer (
        .clock(clock),
        .reset(reset),
        .tick (timer_tick)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        launch_check = 1'b0;
        launch_cpu   = 1'b0;
        case (state)
            ST_IDLE: begin
                // A CPU read waiting behind a finished check goes first unless start is fresh.
                if (start) begin
                    launch_check = 1'b1;
                end else if (cpu_read && after_check) begin
                    launch_cpu = 1'b1;
                end else if (pending || timer_tick) begin
                    launch_check = 1'b1;
                end else if (cpu_read) begin
                    launch_cpu = 1'b1;
                end
                if (launch_check) begin
                    state_nxt = ST_ID_A;
                end else if (launch_cpu) begin
                    state_nxt = ST_CPU_A;
                end
            end
            ST_ID_A:  state_nxt = ST_ID_S;
            ST_ID_S:  state_nxt = ST_TS_A;
            ST_TS_A:  state_nxt = ST_TS_S;
            ST_TS_S:  state_nxt = ST_IDLE;
            ST_CPU_A: state_nxt = ST_CPU_S;
            ST_CPU_S: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            sid_address <= SYSID_ADDR_ID;
            pending     <= AUTO_CHECK;
            after_check <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            captured_ts <= '0;
        end else begin
            state <= state_nxt;

            // Single-deep request flag: requests arriving while one is pending merge.
            if (launch_check) begin
                pending <= 1'b0;
            end else if (start || timer_tick) begin
                pending <= 1'b1;
            end

            if (launch_check) begin
                sid_address <= SYSID_ADDR_ID;
                done        <= 1'b0;
                after_check <= 1'b0;
            end
            if (launch_cpu) begin
                sid_address <= cpu_address;
                after_check <= 1'b0;
            end

            if (state == ST_ID_S) begin
                id_ok       <= (sid_readdata == EXPECTED_ID);
                sid_address <= SYSID_ADDR_TS;
            end
            if (state == ST_TS_S) begin
                captured_ts <= sid_readdata;
                ts_ok       <= (sid_readdata == EXPECTED_TS);
                done        <= 1'b1;
                after_check <= 1'b1;
            end
        end
    end

    assign busy            = pending || (state inside {ST_ID_A, ST_ID_S, ST_TS_A, ST_TS_S});
    assign cpu_waitrequest = reset || (state != ST_CPU_S);
    assign cpu_readdata    = (!reset && state == ST_CPU_S) ? sid_readdata : '0;

endmodule
